// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed D-side priority).
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  // Requester port indices
  localparam logic PORT_I = 1'b0;  // instruction-cache refill
  localparam logic PORT_D = 1'b1;  // data-cache refill / write-back

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot vector for a port index
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter. Round-robin by default: the pointer names the
// preferred port and moves to the other port after every grant.
// With DMEM_ARB_FIXED_PRIO_EN defined, port 1 always wins a tie and the
// pointer flop is not built.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] elig_i,
  input  logic       take_i,
  output logic [1:0] grant_o,
  output logic       win_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  // Clock, reset and strobe have no state to drive in this build
  logic unused_ok;
  assign unused_ok = clk_i ^ rst_i ^ take_i;

  // Fixed priority: D-side first, I-side only when D-side is idle
  always_comb begin
    win_o   = elig_i[PORT_D] ? PORT_D : PORT_I;
    grant_o = (elig_i == 2'b00) ? 2'b00 : port_onehot(win_o);
  end

`else

  logic ptr_q;
  logic ptr_d;

  // Winner selection and pointer advance
  always_comb begin
    win_o = PORT_I;
    if (elig_i == 2'b11) begin
      win_o = ptr_q;
    end else if (elig_i[PORT_D]) begin
      win_o = PORT_D;
    end
    grant_o = (elig_i == 2'b00) ? 2'b00 : port_onehot(win_o);
    ptr_d   = ptr_q;
    if (take_i) begin
      ptr_d = ~win_o;
    end
  end

  // Pointer register, reset prefers the I-side
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= PORT_I;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one line-wide data memory between the I-cache
// refill port (0) and the D-cache refill/write-back port (1).
// One whole-line transaction at a time: IDLE grants and latches the request,
// BUSY holds the memory handshake until mem_ack_i, RESP captures the read
// line and pulses ack_o for the owner. All outputs come straight from flops.
// Handshake: a port holds req_i[p] (with we/addr/wdata stable) until it sees
// ack_o[p]; a port is not eligible in the cycle its ack pulses, so a held
// request is never served twice.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 1 wins ties).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              win;
  logic              take;

  // A port being acked this cycle must not be re-granted on its stale request
  assign elig = req_i & ~ack_q;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .elig_i  (elig),
    .take_i  (take),
    .grant_o (grant),
    .win_o   (win)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ack_d   = 2'b00;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          take    = 1'b1;
          owner_d = win;
          we_d    = we_i[win];
          addr_d  = win ? addr1_i : addr0_i;
          wdata_d = win ? wdata1_i : wdata0_i;
          en_d    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Enable drops with the ack so the memory cannot relaunch
        if (mem_ack_i) begin
          en_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!we_q) begin
          rdata_d = mem_rdata_i;
        end
        ack_d   = port_onehot(owner_q);
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o        = ack_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign mem_enable_o = en_q;
  assign mem_write_o  = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 10-cycle line memory, scripted
// requesters, and an expected-result queue popped on every ack_o pulse.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam logic [DW-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] LINE_5A = {32{8'h5A}};
  localparam logic [DW-1:0] LINE_WR =
    256'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01234567_89ABCDFF;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam logic FIRST = 1'b1;
`else
  localparam logic FIRST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]    req_i = '0;
  logic [1:0]    we_i = '0;
  logic [AW-1:0] addr0_i = '0;
  logic [AW-1:0] addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0;
  logic [DW-1:0] wdata1_i = '0;
  logic [1:0]    ack_o;
  logic [DW-1:0] rdata_o;
  logic          busy_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic [1:0]    dbg_state_o;

  dmem_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr0_i      (addr0_i),
    .addr1_i      (addr1_i),
    .wdata0_i     (wdata0_i),
    .wdata1_i     (wdata1_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- memory model ----------------
  // Samples enable while idle, acks 10 cycles later, read line the cycle after.
  logic [DW-1:0] mem_arr [0:15];
  logic          pre_we = 1'b0;
  logic [3:0]    pre_line = '0;
  logic [DW-1:0] pre_data = '0;
  int            m_st;
  int            m_cnt;
  int            m_launches = 0;
  logic [AW-1:0] m_addr;
  logic          m_we;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_st        <= 0;
      m_cnt       <= 0;
      mem_ack_i   <= 1'b0;
      mem_rdata_i <= '0;
    end else begin
      if (pre_we) mem_arr[pre_line] <= pre_data;
      mem_ack_i <= 1'b0;
      case (m_st)
        0: if (mem_enable_o) begin
          m_st       <= 1;
          m_cnt      <= 9;
          m_addr     <= mem_addr_o;
          m_we       <= mem_write_o;
          m_launches <= m_launches + 1;
          if (mem_write_o) mem_arr[mem_addr_o[8:5]] <= mem_wdata_o;
        end
        1: if (m_cnt == 1) begin
          m_st      <= 2;
          mem_ack_i <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        default: begin
          m_st <= 0;
          if (!m_we) mem_rdata_i <= mem_arr[m_addr[8:5]];
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          port_q[$];
  logic          rd_q[$];
  logic [DW-1:0] sb_last = '0;

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic push_exp(input logic p, input logic rd, input logic [DW-1:0] d);
    port_q.push_back(p);
    rd_q.push_back(rd);
    exp_q.push_back(d);
  endtask

  // Advance to the next falling edge and retire any ack against the queue.
  // A write ack must leave rdata_o at the last line read (0 after reset).
  task automatic tick();
    logic ep;
    logic er;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (!rst_i) begin
      sb_last = '0;
    end else if (ack_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra_ack ack_o=%b with nothing expected (cyc %0d)", ack_o, cyc);
      end else begin
        ep = port_q.pop_front();
        er = rd_q.pop_front();
        ed = exp_q.pop_front();
        if (er) sb_last = ed;
        checks++;
        if (ack_o !== oh(ep)) begin
          errors++;
          $display("FAIL sb_ack_port got %b expected %b (cyc %0d)", ack_o, oh(ep), cyc);
        end
        checks++;
        if (rdata_o !== sb_last) begin
          errors++;
          $display("FAIL sb_rdata got %h expected %h", rdata_o, sb_last);
        end
      end
    end
  endtask

  // ---------------- trace of one scenario, indexed by cycle - N ----------------
  logic [1:0]    tr_ack  [0:127];
  logic          tr_en   [0:127];
  logic          tr_we   [0:127];
  logic          tr_busy [0:127];
  logic [AW-1:0] tr_addr [0:127];
  int            rem [2];

  task automatic clear_log();
    for (int i = 0; i < 128; i++) begin
      tr_ack[i] = '0; tr_en[i] = 1'b0; tr_we[i] = 1'b0;
      tr_busy[i] = 1'b0; tr_addr[i] = '0;
    end
  endtask

  // Run ncyc cycles; each port drops req after its rem[p]-th ack
  task automatic watch(input int n, input int ncyc);
    int idx;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      idx = cyc - n;
      if (idx >= 0 && idx < 128) begin
        tr_ack[idx] = ack_o; tr_en[idx] = mem_enable_o; tr_we[idx] = mem_write_o;
        tr_busy[idx] = busy_o; tr_addr[idx] = mem_addr_o;
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_o[p] && rem[p] > 0) begin
          rem[p]--;
          if (rem[p] == 0) req_i[p] = 1'b0;
        end
      end
    end
  endtask

  function automatic int count_ack(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (tr_ack[i] != 2'b00) c++;
    return c;
  endfunction

  function automatic int first_en(input int lo);
    for (int i = lo; i < 128; i++) if (tr_en[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_i = 1'b0; req_i = '0; we_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic preload(input logic [3:0] line, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_line = line; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (ack_o !== 2'b00) begin errors++; $display("FAIL rst_ack got %b expected 00", ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy_o); end
    checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable got %b expected 0", mem_enable_o); end
    checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rst_write got %b expected 0", mem_write_o); end
    checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata got %h expected 0", mem_wdata_o); end
    checks++; if (rdata_o !== '0) begin errors++; $display("FAIL rst_rdata got %h expected 0", rdata_o); end
    checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL rst_state got %0d expected 0", dbg_state_o); end
  endtask

  task automatic test_single_read();
    int n;
    preload(4'd3, LINE_A5);
    push_exp(1'b0, 1'b1, LINE_A5);
    addr0_i = 32'h60; we_i[0] = 1'b0; req_i[0] = 1'b1;
    rem[0] = 1; rem[1] = 0; n = cyc; clear_log();
    watch(n, 20);
    checks++; if (first_en(0) != 1) begin errors++; $display("FAIL rd_enable_start got N+%0d expected N+1", first_en(0)); end
    checks++; if (tr_addr[1] !== 32'h60) begin errors++; $display("FAIL rd_mem_addr got %h expected 60", tr_addr[1]); end
    checks++; if (tr_ack[13] !== 2'b01) begin errors++; $display("FAIL rd_ack_time got %b at N+13 expected 01", tr_ack[13]); end
    checks++; if (count_ack(0, 20) != 1) begin errors++; $display("FAIL rd_ack_count got %0d expected 1", count_ack(0, 20)); end
    checks++; if (tr_busy[13] !== 1'b0 || tr_busy[12] !== 1'b1) begin
      errors++; $display("FAIL rd_busy got N+12=%b N+13=%b expected 1 0", tr_busy[12], tr_busy[13]);
    end
  endtask

  task automatic test_write_read();
    int n;
    int en_cnt;
    int bad_we;
    push_exp(1'b1, 1'b0, '0);
    addr1_i = 32'h80; wdata1_i = LINE_WR; we_i[1] = 1'b1; req_i[1] = 1'b1;
    rem[0] = 0; rem[1] = 1; n = cyc; clear_log();
    watch(n, 20);
    we_i[1] = 1'b0;
    en_cnt = 0; bad_we = 0;
    for (int i = 0; i < 21; i++) if (tr_en[i]) begin en_cnt++; if (!tr_we[i]) bad_we++; end
    checks++; if (en_cnt != 11) begin errors++; $display("FAIL wr_enable_cycles got %0d expected 11", en_cnt); end
    checks++; if (bad_we != 0) begin errors++; $display("FAIL wr_write_flag got %0d low cycles expected 0", bad_we); end
    checks++; if (tr_ack[13] !== 2'b10) begin errors++; $display("FAIL wr_ack_time got %b expected 10", tr_ack[13]); end
    push_exp(1'b0, 1'b1, LINE_WR);
    addr0_i = 32'h80; we_i[0] = 1'b0; req_i[0] = 1'b1;
    rem[0] = 1; rem[1] = 0; n = cyc; clear_log();
    watch(n, 20);
    checks++; if (tr_ack[13] !== 2'b01) begin errors++; $display("FAIL wr_readback_ack got %b expected 01", tr_ack[13]); end
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    push_exp(FIRST, 1'b1, FIRST ? LINE_WR : LINE_A5);
    push_exp(~FIRST, 1'b1, FIRST ? LINE_A5 : LINE_WR);
    addr0_i = 32'h60; addr1_i = 32'h80; we_i = 2'b00; req_i = 2'b11;
    rem[0] = 1; rem[1] = 1; n = cyc; clear_log();
    watch(n, 30);
    checks++; if (tr_ack[13] !== oh(FIRST)) begin errors++; $display("FAIL ct_first got %b expected %b", tr_ack[13], oh(FIRST)); end
    checks++; if (tr_ack[26] !== oh(~FIRST)) begin errors++; $display("FAIL ct_second got %b expected %b", tr_ack[26], oh(~FIRST)); end
    checks++; if (tr_en[13] !== 1'b0 || tr_en[14] !== 1'b1) begin
      errors++; $display("FAIL ct_regrant got en N+13=%b N+14=%b expected 0 1", tr_en[13], tr_en[14]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int l0;
    logic p;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      p = FIRST ^ t[0];
      push_exp(p, 1'b1, p ? LINE_WR : LINE_A5);
    end
    addr0_i = 32'h60; addr1_i = 32'h80; we_i = 2'b00; req_i = 2'b11;
    rem[0] = 2; rem[1] = 2; n = cyc; l0 = m_launches; clear_log();
    watch(n, 60);
    for (int t = 0; t < 4; t++) begin
      p = FIRST ^ t[0];
      checks++;
      if (tr_ack[13 + 13 * t] !== oh(p)) begin
        errors++; $display("FAIL b2b_ack%0d got %b expected %b", t, tr_ack[13 + 13 * t], oh(p));
      end
    end
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (tr_en[13 + 13 * t] !== 1'b0 || tr_en[14 + 13 * t] !== 1'b1) begin
        errors++; $display("FAIL b2b_gap%0d got en=%b%b expected 01", t, tr_en[13 + 13 * t], tr_en[14 + 13 * t]);
      end
    end
    checks++; if (count_ack(0, 60) != 4) begin errors++; $display("FAIL b2b_ack_count got %0d expected 4", count_ack(0, 60)); end
    checks++; if (m_launches - l0 != 4) begin errors++; $display("FAIL b2b_launches got %0d expected 4", m_launches - l0); end
  endtask

  task automatic test_input_change();
    int n;
    int bad;
    preload(4'd8, LINE_5A);
    push_exp(1'b0, 1'b1, LINE_A5);
    addr0_i = 32'h60; we_i[0] = 1'b0; req_i[0] = 1'b1;
    rem[0] = 1; rem[1] = 0; n = cyc; clear_log();
    watch(n, 4);
    addr0_i = 32'h100; we_i[0] = 1'b1; wdata0_i = {8{$urandom()}};
    watch(n, 16);
    we_i[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 21; i++) if (tr_en[i] && (tr_addr[i] !== 32'h60 || tr_we[i] !== 1'b0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL chg_hold got %0d disturbed cycles expected 0", bad); end
    checks++; if (tr_ack[13] !== 2'b01) begin errors++; $display("FAIL chg_ack got %b expected 01", tr_ack[13]); end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    addr0_i = 32'h60; we_i = 2'b00; req_i = 2'b01;
    rem[0] = 1; rem[1] = 0; n = cyc; clear_log();
    watch(n, 5);
    rst_i = 1'b0;
    #1;
    checks++; if (mem_enable_o !== 1'b0 || busy_o !== 1'b0 || ack_o !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ctrl got en=%b busy=%b ack=%b expected 0 0 00", mem_enable_o, busy_o, ack_o);
    end
    checks++; if (mem_addr_o !== '0 || mem_write_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_addr got addr=%h we=%b expected 0 0", mem_addr_o, mem_write_o);
    end
    checks++; if (rdata_o !== '0 || mem_wdata_o !== '0) begin
      errors++; $display("FAIL mid_rst_data got rdata=%h wdata=%h expected 0", rdata_o, mem_wdata_o);
    end
    checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d expected 0", dbg_state_o); end
    req_i = 2'b00;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    push_exp(1'b1, 1'b1, LINE_WR);
    addr1_i = 32'h80; req_i[1] = 1'b1;
    rem[0] = 0; rem[1] = 1; n = cyc; clear_log();
    watch(n, 20);
    checks++; if (first_en(0) != 1) begin errors++; $display("FAIL post_rst_enable got N+%0d expected N+1", first_en(0)); end
    checks++; if (tr_ack[13] !== 2'b10 || count_ack(0, 20) != 1) begin
      errors++; $display("FAIL post_rst_ack got %b at N+13 count %0d expected 10 count 1", tr_ack[13], count_ack(0, 20));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_input_change();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
